ped_request_conditioner: RTL
============================

PED_REQUEST_CONDITIONER -- requirements
Module: ped_request_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the consecutive stable cycles (>=1) required to accept a button level change.
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 8, the cycles (>=1) after a walk phase during which new requests are refused.
REQ-003 SHALL have parameter CNT_W, default 8, the width of the press counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port btn_raw  input  1  asynchronous, bouncy pedestrian push-button level.
REQ-007 SHALL have port ped_green  input  1  high while the downstream traffic light shows pedestrian green.
REQ-008 SHALL have port ped_req  output  1  request level driving the traffic light pedestrian_btn input.
REQ-009 SHALL have port req_state  output  2  current FSM state (IDLE=0, ARMED=1, SERVING=2, COOLDOWN=3).
REQ-010 SHALL have port press_count  output  CNT_W  saturating count of debounced presses since reset.

Function
REQ-011 SHALL pass btn_raw through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 SHALL hold a debounced level db and counter dcnt; dcnt clears on any edge where s2==db, else increments.
REQ-013 SHALL set db<=s2 and clear dcnt on the DEBOUNCE_CYCLES-th consecutive edge with s2!=db; a shorter disagreement leaves db unchanged.
REQ-014 SHALL define a press event as db==1 and its previous-cycle value db_prev==0; releases are debounced identically but produce no event.
REQ-015 SHALL increment press_count on every press event in any state, saturating at all-ones without wrap.
REQ-016 SHALL, in IDLE: press with ped_green=0 -> ARMED; press with ped_green=1 -> SERVING; otherwise stay.
REQ-017 SHALL, in ARMED: ped_green=1 -> SERVING; presses ignored (counted only).
REQ-018 SHALL, in SERVING: ped_green=0 -> COOLDOWN with cooldown timer cleared to 0; presses ignored.
REQ-019 SHALL, in COOLDOWN: increment timer each cycle; timer==COOLDOWN_CYCLES-1 -> IDLE; presses ignored; ped_green ignored.
REQ-020 SHALL drive ped_req=1 exactly when req_state==ARMED, decoded from the registered state (no combinational path from btn_raw or ped_green).
REQ-021 SHALL assert ped_req after edge N+DEBOUNCE_CYCLES+2, where N is the first edge sampling btn_raw=1 held stable in IDLE with ped_green=0.
REQ-022 SHALL size the cooldown timer and dcnt to hold their parameter values with no overflow.
REQ-023 SHALL hold ped_req high continuously in ARMED until ped_green is seen, irrespective of button release.

Reset
REQ-024 SHALL, on any edge with rst=1, clear s1, s2, db, db_prev, dcnt, cooldown timer, press_count to 0 and set req_state=IDLE.
REQ-025 SHALL have ped_req=0, req_state=0, press_count=0 in the cycle following a reset edge, including reset asserted mid-ARMED or mid-COOLDOWN.
REQ-026 SHALL ignore btn_raw and ped_green while rst=1; a button held through reset is re-debounced from db=0 after release of rst.

Verification
REQ-027 SHALL verify clean press: D=4, btn_raw 0->1 sampled at edge 0 and held -> ped_req=1 after edge 6, press_count=1, req_state=1.
REQ-028 SHALL verify glitch rejection: btn_raw high for 3 edges then low, D=4 -> ped_req stays 0, press_count stays 0.
REQ-029 SHALL verify service cycle: ARMED, ped_green 0->1 -> req_state=2 and ped_req=0 next cycle; ped_green 1->0 -> COOLDOWN for exactly 8 cycles then IDLE.
REQ-030 SHALL verify cooldown lockout: debounced press during COOLDOWN -> press_count increments, req_state stays 3, ped_req stays 0.
REQ-031 SHALL verify press during unrequested walk: IDLE, ped_green=1, debounced press -> req_state=2 directly, ped_req never asserted.
REQ-032 SHALL verify reset mid-ARMED and saturation: rst=1 one edge in ARMED -> ped_req=0, press_count=0; CNT_W=2, 5 presses -> press_count=3.

Source files
------------

// File: rtl/ped_request_conditioner.sv
// Pedestrian request conditioner: synchronizes and debounces a raw push-button,
// counts debounced presses, and sequences a request level towards the traffic
// light through IDLE / ARMED / SERVING / COOLDOWN.
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             ped_green,
  output logic             ped_req,
  output logic [1:0]       req_state,
  output logic [CNT_W-1:0] press_count
);

  // Counters are sized to hold their full parameter value, so they never wrap.
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CD_W   = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SERVING  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  logic              r_s1;
  logic              r_s2;
  logic              r_db;
  logic              r_dbPrev;
  logic [DCNT_W-1:0] r_dcnt;
  logic [CD_W-1:0]   r_timer;
  logic [CNT_W-1:0]  r_pressCount;
  state_t            r_state;
  state_t            w_stateNext;
  logic [CD_W-1:0]   w_timerNext;
  logic              w_press;

  // Two-flop synchronizer; the raw button is not used anywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db     <= 1'b0;
      r_dbPrev <= 1'b0;
      r_dcnt   <= '0;
    end else begin
      r_dbPrev <= r_db;
      if (r_s2 == r_db) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DCNT_LAST) begin
        r_db   <= r_s2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DCNT_W'(1);
      end
    end
  end

  // A press is the rising edge of the debounced level; releases are silent.
  assign w_press = r_db & ~r_dbPrev;

  // Saturating press counter, counting in every FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pressCount <= '0;
    end else if (w_press && (r_pressCount != '1)) begin
      r_pressCount <= r_pressCount + CNT_W'(1);
    end
  end

  // State and cooldown timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_stateNext;
      r_timer <= w_timerNext;
    end
  end

  // Next-state logic; presses only matter in IDLE, ped_green is ignored during cooldown.
  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    unique case (r_state)
      IDLE: begin
        if (w_press) begin
          w_stateNext = ped_green ? SERVING : ARMED;
        end
      end
      ARMED: begin
        if (ped_green) begin
          w_stateNext = SERVING;
        end
      end
      SERVING: begin
        if (!ped_green) begin
          w_stateNext = COOLDOWN;
          w_timerNext = '0;
        end
      end
      COOLDOWN: begin
        if (r_timer == CD_LAST) begin
          w_stateNext = IDLE;
          w_timerNext = '0;
        end else begin
          w_timerNext = r_timer + CD_W'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_timerNext = '0;
      end
    endcase
  end

  assign ped_req     = (r_state == ARMED);
  assign req_state   = r_state;
  assign press_count = r_pressCount;

endmodule
